// File: rtl/mux_rr_arbiter.sv
// Two-source round-robin arbiter feeding a single-entry output register.
// Ties alternate between A and B; the held word reloads in the same cycle it is consumed.
module mux_rr_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic [19:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [19:0] b_data,
  output logic        b_ready,
  output logic        sel,
  output logic        d_valid,
  output logic [19:0] d_data,
  input  logic        d_ready,
  output logic [7:0]  cnt_a,
  output logic [7:0]  cnt_b
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t state;
  logic   last_grant;   // 0 = A, 1 = B
  logic   slot_free;
  logic   grant_valid;
  logic   grant_b;
  logic   accept;

  assign slot_free   = (state == EMPTY) | d_ready;
  assign grant_valid = a_valid | b_valid;
  // B wins when it is alone, or on a tie when A was granted last
  assign grant_b     = b_valid & (~a_valid | ~last_grant);
  assign accept      = slot_free & grant_valid;

  assign a_ready = accept & ~grant_b;
  assign b_ready = accept & grant_b;
  assign d_valid = (state == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      d_data     <= 20'h00000;
      sel        <= 1'b0;
      last_grant <= 1'b1;
      cnt_a      <= 8'd0;
      cnt_b      <= 8'd0;
    end else if (accept) begin
      state      <= FULL;
      d_data     <= grant_b ? b_data : a_data;
      sel        <= grant_b;
      last_grant <= grant_b;
      if (grant_b) cnt_b <= cnt_b + 8'd1;
      else         cnt_a <= cnt_a + 8'd1;
    end else if (d_ready) begin
      // consumed with nothing to reload; d_data keeps its last value
      state <= EMPTY;
    end
  end

endmodule
